// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 key decoder: prefix tracking, typematic repeat
// suppression and a 4-entry key-event FIFO drained with valid/ack.
module ps2_key_decoder (
    input  logic       clk,
    input  logic       iRST_n,
    input  logic [7:0] iSCANCODE,
    input  logic       iPS2_READY,
    input  logic       iKEY_ACK,
    output logic [3:0] oKEY,
    output logic       oKEY_VALID,
    output logic       oOVF,
    output logic       oHELD
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_F0 = 8'hF0;

    state_t     state_q, state_d;
    logic       rdy_q;
    logic       strobe;

    logic       dec_make;
    logic       dec_break;
    logic       dec_ext;
    logic       map_hit;
    logic [3:0] map_key;

    logic [7:0] held_code_q, held_code_d;
    logic       held_ext_q, held_ext_d;
    logic       held_flag_q, held_flag_d;
    logic       held_match;
    logic       push_evt;

    logic [3:0] mem_q [4];
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0] count_q, count_d;
    logic       ovf_q, ovf_d;
    logic       fifo_full;
    logic       do_pop;
    logic       do_write;

    // A byte is taken only on the falling edge of the active-low ready.
    assign strobe = rdy_q & ~iPS2_READY;

    // Prefix FSM next state and classification of the accepted byte.
    always_comb begin
        state_d   = state_q;
        dec_make  = 1'b0;
        dec_break = 1'b0;
        dec_ext   = 1'b0;
        if (strobe) begin
            case (state_q)
                ST_IDLE: begin
                    if (iSCANCODE == CODE_E0) begin
                        state_d = ST_EXT;
                    end else if (iSCANCODE == CODE_F0) begin
                        state_d = ST_BRK;
                    end else begin
                        dec_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (iSCANCODE == CODE_E0) begin
                        state_d = ST_EXT;
                    end else if (iSCANCODE == CODE_F0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        dec_make = 1'b1;
                        dec_ext  = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    dec_break = 1'b1;
                    state_d   = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    dec_break = 1'b1;
                    dec_ext   = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Scan code (with extended flag) to calculator key.
    always_comb begin
        map_hit = 1'b1;
        map_key = 4'h0;
        case ({dec_ext, iSCANCODE})
            9'h045: map_key = 4'h0;
            9'h016: map_key = 4'h1;
            9'h01E: map_key = 4'h2;
            9'h026: map_key = 4'h3;
            9'h025: map_key = 4'h4;
            9'h02E: map_key = 4'h5;
            9'h036: map_key = 4'h6;
            9'h03D: map_key = 4'h7;
            9'h03E: map_key = 4'h8;
            9'h046: map_key = 4'h9;
            9'h070: map_key = 4'h0;
            9'h069: map_key = 4'h1;
            9'h072: map_key = 4'h2;
            9'h07A: map_key = 4'h3;
            9'h06B: map_key = 4'h4;
            9'h073: map_key = 4'h5;
            9'h074: map_key = 4'h6;
            9'h06C: map_key = 4'h7;
            9'h075: map_key = 4'h8;
            9'h07D: map_key = 4'h9;
            9'h079: map_key = 4'hA;
            9'h07B: map_key = 4'hB;
            9'h04E: map_key = 4'hB;
            9'h07C: map_key = 4'hC;
            9'h04A: map_key = 4'hD;
            9'h055: map_key = 4'hE;
            9'h05A: map_key = 4'hE;
            9'h076: map_key = 4'hF;
            9'h14A: map_key = 4'hD;
            9'h15A: map_key = 4'hE;
            default: map_hit = 1'b0;
        endcase
    end

    // Held-key tracking: a repeated make of the held key is a typematic repeat.
    always_comb begin
        held_code_d = held_code_q;
        held_ext_d  = held_ext_q;
        held_flag_d = held_flag_q;
        held_match  = (held_code_q == iSCANCODE) && (held_ext_q == dec_ext);
        push_evt    = 1'b0;
        if (dec_make && map_hit && !(held_flag_q && held_match)) begin
            push_evt    = 1'b1;
            held_code_d = iSCANCODE;
            held_ext_d  = dec_ext;
            held_flag_d = 1'b1;
        end else if (dec_break && map_hit && held_match) begin
            held_flag_d = 1'b0;
        end
    end

    // FIFO control; a pop frees the slot a simultaneous push into a full FIFO needs.
    always_comb begin
        fifo_full = (count_q == 3'd4);
        do_pop    = iKEY_ACK && (count_q != 3'd0);
        do_write  = push_evt && (!fifo_full || do_pop);
        ovf_d     = ovf_q || (push_evt && fifo_full && !do_pop);
        rd_ptr_d  = do_pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        wr_ptr_d  = do_write ? wr_ptr_q + 2'd1 : wr_ptr_q;
        count_d   = count_q + {2'b00, do_write} - {2'b00, do_pop};
    end

    // State, pointer and flag registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b1;
            held_code_q <= 8'h00;
            held_ext_q  <= 1'b0;
            held_flag_q <= 1'b0;
            rd_ptr_q    <= 2'd0;
            wr_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= iPS2_READY;
            held_code_q <= held_code_d;
            held_ext_q  <= held_ext_d;
            held_flag_q <= held_flag_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    // FIFO storage; contents need no reset because the count gates the head.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= map_key;
        end
    end

    assign oKEY_VALID = (count_q != 3'd0);
    assign oKEY       = oKEY_VALID ? mem_q[rd_ptr_q] : 4'h0;
    assign oOVF       = ovf_q;
    assign oHELD      = held_flag_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random
// byte streams compared against a queue-based reference model.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       iRST_n = 1'b0;
    logic [7:0] iSCANCODE = 8'h00;
    logic       iPS2_READY = 1'b1;
    logic       iKEY_ACK = 1'b0;
    logic [3:0] oKEY;
    logic       oKEY_VALID;
    logic       oOVF;
    logic       oHELD;

    ps2_key_decoder dut (
        .clk        (clk),
        .iRST_n     (iRST_n),
        .iSCANCODE  (iSCANCODE),
        .iPS2_READY (iPS2_READY),
        .iKEY_ACK   (iKEY_ACK),
        .oKEY       (oKEY),
        .oKEY_VALID (oKEY_VALID),
        .oOVF       (oOVF),
        .oHELD      (oHELD)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Key table entries: {ext, code[7:0], key[3:0]}.
    int map_tbl[30] = '{
        'h0450, 'h0161, 'h01E2, 'h0263, 'h0254, 'h02E5, 'h0366, 'h03D7, 'h03E8, 'h0469,
        'h0700, 'h0691, 'h0722, 'h07A3, 'h06B4, 'h0735, 'h0746, 'h06C7, 'h0758, 'h07D9,
        'h079A, 'h07BB, 'h04EB, 'h07CC, 'h04AD, 'h055E, 'h05AE, 'h076F, 'h14AD, 'h15AE
    };
    int keymap[int];
    byte unsigned junk_tbl[8] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1, 8'h14, 8'h77, 8'h00};

    // Reference model state.
    bit          m_rdy;
    bit          m_pend_ext;
    bit          m_pend_brk;
    bit          m_held;
    byte unsigned m_held_code;
    bit          m_held_ext;
    bit          m_ovf;
    int          m_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lookup(input bit ext, input byte unsigned code);
        int idx = (ext ? 256 : 0) + int'(code);
        if (keymap.exists(idx)) return keymap[idx];
        return -1;
    endfunction

    task automatic model_reset();
        m_rdy = 1; m_pend_ext = 0; m_pend_brk = 0;
        m_held = 0; m_held_code = 0; m_held_ext = 0; m_ovf = 0;
        m_q.delete();
    endtask

    // One rising edge of the reference model.
    task automatic model_edge(input bit rdy, input byte unsigned code, input bit ack);
        bit strobe = !rdy && m_rdy;
        int sz = m_q.size();
        bit pop = ack && (sz > 0);
        bit push = 0;
        int k = -1;
        m_rdy = rdy;
        if (strobe) begin
            if (m_pend_brk) begin
                k = lookup(m_pend_ext, code);
                if (k >= 0 && m_held_code == code && m_held_ext == m_pend_ext) m_held = 0;
                m_pend_brk = 0; m_pend_ext = 0;
            end else if (code == 8'hE0) begin
                m_pend_ext = 1;
            end else if (code == 8'hF0) begin
                m_pend_brk = 1;
            end else begin
                k = lookup(m_pend_ext, code);
                if (k >= 0 && !(m_held && m_held_code == code && m_held_ext == m_pend_ext)) begin
                    push = 1;
                    m_held = 1; m_held_code = code; m_held_ext = m_pend_ext;
                end
                m_pend_ext = 0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (sz == 4 && !pop) m_ovf = 1;
            else m_q.push_back(k);
        end
    endtask

    task automatic compare_all();
        check("key",   int'(oKEY),       m_q.size() > 0 ? m_q[0] : 0);
        check("valid", int'(oKEY_VALID), m_q.size() > 0 ? 1 : 0);
        check("ovf",   int'(oOVF),       int'(m_ovf));
        check("held",  int'(oHELD),      int'(m_held));
    endtask

    task automatic step(input bit rdy, input byte unsigned code, input bit ack);
        @(negedge clk);
        iPS2_READY = rdy; iSCANCODE = code; iKEY_ACK = ack;
        @(posedge clk);
        model_edge(rdy, code, ack);
        #1;
        compare_all();
    endtask

    task automatic send_byte(input byte unsigned code, input bit ack_on_strobe);
        step(1'b0, code, ack_on_strobe);
        step(1'b0, code, 1'b0);
        step(1'b1, code, 1'b0);
        $display("byte %02h ack=%0d -> key=%h valid=%0d ovf=%0d held=%0d depth=%0d",
                 code, ack_on_strobe, oKEY, oKEY_VALID, oOVF, oHELD, m_q.size());
    endtask

    task automatic ack_one();
        step(1'b1, 8'h00, 1'b1);
    endtask

    task automatic drain_expect(input int exp_key);
        check("head", int'(oKEY), exp_key);
        ack_one();
    endtask

    initial begin
        byte unsigned b;
        byte unsigned last_make;
        int lo;
        int hi;
        int r;

        foreach (map_tbl[i]) keymap[map_tbl[i] >> 4] = map_tbl[i] & 'hF;
        model_reset();
        last_make = 8'h16;
        repeat (3) @(negedge clk);
        iRST_n = 1'b1;
        #1;
        compare_all();
        check("rst_valid", int'(oKEY_VALID), 0);

        // Make / break of digit 1.
        send_byte(8'h16, 0);
        check("held_after_make", int'(oHELD), 1);
        send_byte(8'hF0, 0);
        send_byte(8'h16, 0);
        check("held_after_break", int'(oHELD), 0);
        drain_expect(1);
        check("empty_after_ack", int'(oKEY_VALID), 0);

        // Typematic repeat suppression.
        send_byte(8'h2E, 0); send_byte(8'h2E, 0); send_byte(8'h2E, 0);
        send_byte(8'hF0, 0); send_byte(8'h2E, 0); send_byte(8'h2E, 0);
        check("typ_held", int'(oHELD), 1);
        drain_expect(5);
        drain_expect(5);
        check("typ_empty", int'(oKEY_VALID), 0);

        // Extended codes.
        send_byte(8'hE0, 0); send_byte(8'h5A, 0);
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h5A, 0);
        send_byte(8'h5A, 0);
        send_byte(8'hE0, 0); send_byte(8'h4A, 0);
        send_byte(8'hE0, 0); send_byte(8'h70, 0);
        drain_expect('hE);
        drain_expect('hE);
        drain_expect('hD);
        check("ext70_none", int'(oKEY_VALID), 0);
        send_byte(8'h70, 0);
        drain_expect(0);

        // Overflow.
        send_byte(8'h45, 0); send_byte(8'h16, 0); send_byte(8'h1E, 0);
        send_byte(8'h26, 0); send_byte(8'h25, 0);
        check("ovf_set", int'(oOVF), 1);
        drain_expect(0); drain_expect(1); drain_expect(2); drain_expect(3);
        check("ovf_empty", int'(oKEY_VALID), 0);
        check("ovf_sticky", int'(oOVF), 1);

        // Push and pop together on a full FIFO.
        send_byte(8'h46, 0); send_byte(8'h36, 0); send_byte(8'h3D, 0); send_byte(8'h3E, 0);
        send_byte(8'h7C, 1);
        drain_expect(6); drain_expect(7); drain_expect(8); drain_expect('hC);
        check("full_pp_empty", int'(oKEY_VALID), 0);

        // Reset in the middle of a break prefix.
        send_byte(8'h74, 0);
        send_byte(8'hF0, 0);
        @(posedge clk);
        #3 iRST_n = 1'b0;
        #1;
        model_reset();
        check("rst_key", int'(oKEY), 0);
        check("rst_valid2", int'(oKEY_VALID), 0);
        check("rst_ovf", int'(oOVF), 0);
        check("rst_held", int'(oHELD), 0);
        @(negedge clk);
        @(negedge clk);
        iRST_n = 1'b1;
        send_byte(8'h76, 0);
        check("post_rst_key", int'(oKEY), 'hF);
        ack_one();

        // Random byte streams with random consumer acks.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 25)      b = last_make;
            else if (r < 55) b = 8'((map_tbl[$urandom_range(0, 27)] >> 4) & 'hFF);
            else if (r < 70) b = 8'hE0;
            else if (r < 85) b = 8'hF0;
            else             b = junk_tbl[$urandom_range(0, 7)];
            if (b != 8'hE0 && b != 8'hF0) last_make = b;
            lo = $urandom_range(1, 3);
            hi = $urandom_range(1, 2);
            for (int c = 0; c < lo; c++) step(1'b0, b, ($urandom_range(0, 3) == 0));
            for (int c = 0; c < hi; c++) step(1'b1, b, ($urandom_range(0, 3) == 0));
            $display("rnd byte %02h -> key=%h valid=%0d ovf=%0d held=%0d depth=%0d",
                     b, oKEY, oKEY_VALID, oOVF, oHELD, m_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
